// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, execution-unit selects and flag bit positions shared by the ALU pipe.
package alu_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00_000;
  localparam logic [4:0] OP_SUB  = 5'b00_001;
  localparam logic [4:0] OP_INC  = 5'b00_010;
  localparam logic [4:0] OP_DEC  = 5'b00_011;
  localparam logic [4:0] OP_MUL  = 5'b00_100;
  localparam logic [4:0] OP_AND  = 5'b01_000;
  localparam logic [4:0] OP_OR   = 5'b01_001;
  localparam logic [4:0] OP_XOR  = 5'b01_010;
  localparam logic [4:0] OP_NAND = 5'b01_011;
  localparam logic [4:0] OP_NOR  = 5'b01_100;
  localparam logic [4:0] OP_ANDN = 5'b01_101;
  localparam logic [4:0] OP_XNOR = 5'b01_110;
  localparam logic [4:0] OP_SLL  = 5'b10_000;
  localparam logic [4:0] OP_SRL  = 5'b10_001;
  localparam logic [4:0] OP_SRA  = 5'b10_010;
  localparam logic [1:0] UNIT_ARITH   = 2'b00;
  localparam logic [1:0] UNIT_LOGIC   = 2'b01;
  localparam logic [1:0] UNIT_SHIFT   = 2'b10;
  localparam logic [1:0] UNIT_ILLEGAL = 2'b11;
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_ZERO    = 1;
  localparam int FLAG_NEG     = 2;
  localparam int FLAG_ILLEGAL = 3;
endpackage

// File: rtl/alu.sv
// alu: combinational arithmetic/logic/shift unit; carry_out is the carry for add/inc and the borrow for sub/dec.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [4:0]              opcode,
  input  logic [SHIFT_BITS-1:0]   shift,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [2*DATA_WIDTH-1:0] mult,
  output logic                    carry_out,
  output logic                    illegal
);
  localparam int W = DATA_WIDTH;
  logic [1:0] unit;
  logic [W:0] sum;
  logic [W-1:0] logic_res, shift_res;
  logic signed [W-1:0] sra_res;
  always_comb begin
    unit = opcode[4:3];
    sum = opcode == OP_ADD ? {1'b0, a} + {1'b0, b} :
          opcode == OP_SUB ? {1'b0, a} - {1'b0, b} :
          opcode == OP_INC ? {1'b0, a} + (W+1)'(1) :
          opcode == OP_DEC ? {1'b0, a} - (W+1)'(1) : '0;
    mult = opcode == OP_MUL ? {{W{1'b0}}, a} * {{W{1'b0}}, b} : '0;
    logic_res = opcode == OP_AND  ? a & b :
                opcode == OP_OR   ? a | b :
                opcode == OP_XOR  ? a ^ b :
                opcode == OP_NAND ? ~(a & b) :
                opcode == OP_NOR  ? ~(a | b) :
                opcode == OP_ANDN ? a & ~b :
                opcode == OP_XNOR ? ~(a ^ b) : '0;
    // kept in its own signed variable so the arithmetic shift is not turned logical by unsigned context
    sra_res = $signed(a) >>> shift;
    shift_res = opcode == OP_SLL ? a << shift :
                opcode == OP_SRL ? a >> shift :
                opcode == OP_SRA ? sra_res : '0;
    result = unit == UNIT_ARITH ? (opcode == OP_MUL ? mult[W-1:0] : sum[W-1:0]) :
             unit == UNIT_LOGIC ? logic_res :
             unit == UNIT_SHIFT ? shift_res : '0;
    carry_out = sum[W];
    illegal = unit == UNIT_ILLEGAL;
  end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: ALU feeding a DEPTH-entry result FIFO with registered head outputs.
// Optional ALU_EXEC_PIPE_STATS_EN adds saturating stat_ops / stat_carry counters.
module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BITS = $clog2(DATA_WIDTH),
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [4:0]              in_opcode,
  input  logic [SHIFT_BITS-1:0]   in_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [2*DATA_WIDTH-1:0] out_mult,
  output logic [3:0]              out_flags
`ifdef ALU_EXEC_PIPE_STATS_EN
  ,
  output logic [31:0]             stat_ops,
  output logic [31:0]             stat_carry
`endif
);
  localparam int W = DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] alu_result;
  logic [2*W-1:0] alu_mult;
  logic alu_carry, alu_illegal, arith_op, is_mul, push, pop, bypass;
  logic [3:0] new_flags;
  logic [PW-1:0] rd, wr, rd_next, wr_next;
  logic [CW-1:0] count, count_next;
  logic [W-1:0] mem_result [DEPTH];
  logic [2*W-1:0] mem_mult [DEPTH];
  logic [3:0] mem_flags [DEPTH];

  alu #(.DATA_WIDTH(W), .SHIFT_BITS(SHIFT_BITS)) u_alu (
    .a(in_a), .b(in_b), .opcode(in_opcode), .shift(in_shift),
    .result(alu_result), .mult(alu_mult), .carry_out(alu_carry), .illegal(alu_illegal)
  );

  assign in_ready = count < FULL;
  assign out_valid = count != '0;

  always_comb begin
    arith_op = in_opcode[4:2] == 3'b000;
    is_mul = in_opcode == OP_MUL;
    new_flags[FLAG_ILLEGAL] = alu_illegal;
    new_flags[FLAG_NEG] = is_mul ? alu_mult[2*W-1] : alu_result[W-1];
    new_flags[FLAG_ZERO] = is_mul ? alu_mult == '0 : alu_result == '0;
    new_flags[FLAG_CARRY] = arith_op & alu_carry;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    rd_next = pop ? rd + PW'(1) : rd;
    wr_next = push ? wr + PW'(1) : wr;
    count_next = count + CW'(push) - CW'(pop);
    // the new head is the entry being written this edge when the read pointer lands on the write slot
    bypass = push && rd_next == wr;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr] <= alu_result;
      mem_mult[wr] <= alu_mult;
      mem_flags[wr] <= new_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      out_result <= '0;
      out_mult <= '0;
      out_flags <= '0;
`ifdef ALU_EXEC_PIPE_STATS_EN
      stat_ops <= '0;
      stat_carry <= '0;
`endif
    end else begin
      rd <= rd_next;
      wr <= wr_next;
      count <= count_next;
      if (count_next != '0) begin
        out_result <= bypass ? alu_result : mem_result[rd_next];
        out_mult <= bypass ? alu_mult : mem_mult[rd_next];
        out_flags <= bypass ? new_flags : mem_flags[rd_next];
      end
`ifdef ALU_EXEC_PIPE_STATS_EN
      if (push && stat_ops != '1) stat_ops <= stat_ops + 32'd1;
      if (push && new_flags[FLAG_CARRY] && stat_carry != '1) stat_carry <= stat_carry + 32'd1;
`endif
    end
  end
endmodule
